ahb_lite_2to1_rr_arb: RTL and testbench
=======================================

AHB_LITE_2TO1_RR_ARB -- requirements
Module: ahb_lite_2to1_rr_arb

Interface
REQ-001 SHALL have parameter AHB_LITE_ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter AHB_LITE_DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, grant-counter width.
REQ-004 hclk  input  1  single clock; all state updates on its rising edge.
REQ-005 hreset  input  1  reset, synchronous, active-high.
REQ-006 hsel_i_n, hwrite_i_n, hready_i_n  input  1 each (n=0,1)  initiator-n select, write, bus-ready.
REQ-007 haddr_i_n / hwdata_i_n  input  ADDR / DATA  initiator-n address / write data.
REQ-008 htrans_i_n / hsize_i_n  input  2 / 3  initiator-n transfer type / size.
REQ-009 hresp_o_n, hready_o_n  output  1 each  response and ready to initiator n.
REQ-010 hrdata_o_n  output  DATA  read data to initiator n.
REQ-011 hresp_i, hreadyout_i  input  1 each  responder response and ready.
REQ-012 hrdata_i  input  DATA  responder read data.
REQ-013 haddr_o, hwdata_o  output  ADDR, DATA  to responder.
REQ-014 hsel_o, hwrite_o, hready_o  output  1 each  to responder.
REQ-015 htrans_o, hsize_o  output  2, 3  to responder.
REQ-016 gnt_cnt_o_0, gnt_cnt_o_1  output  CNT_WIDTH each  grants issued per initiator.
REQ-017 cnt_clr_i  input  1  synchronous clear of both grant counters.

Function
REQ-018 addr_ph_n SHALL be hsel_i_n & hready_i_n & htrans_i_n[1] (NONSEQ/SEQ); req_n = addr_ph_n | pend_n.
REQ-019 Grant SHALL be issued only when hreadyout_i=1; at most one of gnt_0/gnt_1 per cycle.
REQ-020 Single requester SHALL be granted; both requesting SHALL grant the initiator != last_gnt (round-robin).
REQ-021 last_gnt SHALL update to the granted index on every grant; unchanged otherwise.
REQ-022 addr_ph_n without gnt_n SHALL capture haddr/htrans/hsize/hwrite into pending regs and set pend_n next cycle.
REQ-023 pend_n SHALL clear on the cycle after gnt_n; pending regs SHALL NOT be overwritten while pend_n=1.
REQ-024 Granted initiator's address controls SHALL come from pending regs when pend_n=1, else live inputs.
REQ-025 On gnt_n: haddr_o/htrans_o/hsize_o/hwrite_o from initiator n, hsel_o=1; no grant: hsel_o=0, htrans_o=IDLE(00), others hold last value.
REQ-026 dph_n SHALL be registered: dph_n <= gnt_n | (dph_n & ~hreadyout_i); dph_0 & dph_1 never both 1.
REQ-027 hwdata_o SHALL be hwdata_i_1 when dph_1, else hwdata_i_0.
REQ-028 hready_o SHALL equal hreadyout_i.
REQ-029 hready_o_n SHALL be 0 when pend_n; else hreadyout_i when dph_n; else 1.
REQ-030 hresp_o_n / hrdata_o_n SHALL pass hresp_i / hrdata_i when dph_n, else 0.
REQ-031 Two-cycle ERROR response SHALL pass through unmodified to data-phase owner; no new grant while hreadyout_i=0.
REQ-032 Latency: uncontended transfer SHALL reach responder same cycle (zero added cycles); loser SHALL add exactly one cycle per lost arbitration.
REQ-033 gnt_cnt_o_n SHALL increment by 1 per gnt_n, saturate at all-ones; cnt_clr_i wins over same-cycle increment.
REQ-034 htrans_o SHALL never be BUSY(01); BUSY/IDLE from initiators SHALL not generate requests.

Reset
REQ-035 hreset=1 at a rising edge SHALL clear pend_n, dph_n, pending regs, counters, and set last_gnt=1 (initiator 0 wins first contention).
REQ-036 During/after reset: hsel_o=0, htrans_o=00, haddr_o=0, hready_o_n=1, hresp_o_n=0, hrdata_o_n=0.
REQ-037 Reset mid-transfer SHALL discard pending and data-phase state without further responder grant.

Verification
REQ-038 Init0 alone, write 0x1000, hreadyout_i=1 -> same-cycle hsel_o=1, haddr_o=0x1000; gnt_cnt_o_0=1.
REQ-039 Both NONSEQ same cycle after reset (0x10, 0x20) -> 0x10 first, 0x20 next cycle from pending; hready_o_1=0 one cycle.
REQ-040 Both streaming back-to-back 8 transfers each -> strict alternation 0,1,0,1...; both counters=8.
REQ-041 Responder wait states hreadyout_i=0 for 3 cycles during init1 data phase -> no grant, dph_1 held, hready_o_1=0 three cycles.
REQ-042 hresp_i=1 two cycles to init0 -> hresp_o_0=1 both cycles, hresp_o_1=0; counter at all-ones plus grant stays all-ones.
REQ-043 hreset asserted with pend_1=1 -> next cycle pend_1=0, hsel_o=0, hready_o_1=1, counters=0.

Source files
------------

// File: rtl/ahb_lite_2to1_rr_arb.sv
// rtl/ahb_lite_2to1_rr_arb.sv - two-initiator AHB-Lite round-robin arbiter with one-deep pending stage per initiator
module ahb_lite_2to1_rr_arb #(
    parameter int AHB_LITE_ADDR_WIDTH = 32,
    parameter int AHB_LITE_DATA_WIDTH = 32,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic                           hsel_i_0,
    input  logic                           hwrite_i_0,
    input  logic                           hready_i_0,
    input  logic [AHB_LITE_ADDR_WIDTH-1:0] haddr_i_0,
    input  logic [AHB_LITE_DATA_WIDTH-1:0] hwdata_i_0,
    input  logic [1:0]                     htrans_i_0,
    input  logic [2:0]                     hsize_i_0,
    input  logic                           hsel_i_1,
    input  logic                           hwrite_i_1,
    input  logic                           hready_i_1,
    input  logic [AHB_LITE_ADDR_WIDTH-1:0] haddr_i_1,
    input  logic [AHB_LITE_DATA_WIDTH-1:0] hwdata_i_1,
    input  logic [1:0]                     htrans_i_1,
    input  logic [2:0]                     hsize_i_1,
    output logic                           hresp_o_0,
    output logic                           hready_o_0,
    output logic [AHB_LITE_DATA_WIDTH-1:0] hrdata_o_0,
    output logic                           hresp_o_1,
    output logic                           hready_o_1,
    output logic [AHB_LITE_DATA_WIDTH-1:0] hrdata_o_1,
    input  logic                           hresp_i,
    input  logic                           hreadyout_i,
    input  logic [AHB_LITE_DATA_WIDTH-1:0] hrdata_i,
    output logic [AHB_LITE_ADDR_WIDTH-1:0] haddr_o,
    output logic [AHB_LITE_DATA_WIDTH-1:0] hwdata_o,
    output logic                           hsel_o,
    output logic                           hwrite_o,
    output logic                           hready_o,
    output logic [1:0]                     htrans_o,
    output logic [2:0]                     hsize_o,
    output logic [CNT_WIDTH-1:0]           gnt_cnt_o_0,
    output logic [CNT_WIDTH-1:0]           gnt_cnt_o_1,
    input  logic                           cnt_clr_i
);
    localparam int AW = AHB_LITE_ADDR_WIDTH;

    logic [1:0]    addr_ph, req, gnt, pend, dph, live_dph;
    logic          last_gnt, grant_any, sel;
    logic [AW-1:0] live_addr [2];
    logic [AW-1:0] pend_addr [2];
    logic [AW-1:0] cand_addr [2];
    logic [1:0]    live_trans [2];
    logic [1:0]    pend_trans [2];
    logic [1:0]    cand_trans [2];
    logic [2:0]    live_size [2];
    logic [2:0]    pend_size [2];
    logic [2:0]    cand_size [2];
    logic [1:0]    live_write, pend_write, cand_write;
    logic [AW-1:0] haddr_q;
    logic [2:0]    hsize_q;
    logic          hwrite_q;
    logic [CNT_WIDTH-1:0] cnt [2];

    assign live_addr[0]  = haddr_i_0;
    assign live_addr[1]  = haddr_i_1;
    assign live_trans[0] = htrans_i_0;
    assign live_trans[1] = htrans_i_1;
    assign live_size[0]  = hsize_i_0;
    assign live_size[1]  = hsize_i_1;
    assign live_write    = {hwrite_i_1, hwrite_i_0};

    // Only NONSEQ/SEQ count as address phases; IDLE and BUSY never request.
    assign addr_ph[0] = hsel_i_0 & hready_i_0 & htrans_i_0[1];
    assign addr_ph[1] = hsel_i_1 & hready_i_1 & htrans_i_1[1];
    assign req        = addr_ph | pend;

    always_comb begin
        gnt = 2'b00;
        if (!hreset && hreadyout_i) begin
            if (req[0] && (!req[1] || last_gnt)) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cand_addr[i]  = pend[i] ? pend_addr[i]  : live_addr[i];
            cand_trans[i] = pend[i] ? pend_trans[i] : live_trans[i];
            cand_size[i]  = pend[i] ? pend_size[i]  : live_size[i];
            cand_write[i] = pend[i] ? pend_write[i] : live_write[i];
        end
    end

    assign grant_any = |gnt;
    assign sel       = gnt[1];
    assign hsel_o    = grant_any;
    assign htrans_o  = grant_any ? cand_trans[sel] : 2'b00;
    assign haddr_o   = grant_any ? cand_addr[sel]  : (hreset ? '0 : haddr_q);
    assign hsize_o   = grant_any ? cand_size[sel]  : (hreset ? 3'b000 : hsize_q);
    assign hwrite_o  = grant_any ? cand_write[sel] : (hreset ? 1'b0 : hwrite_q);
    assign hwdata_o  = dph[1] ? hwdata_i_1 : hwdata_i_0;
    assign hready_o  = hreadyout_i;

    // Response path is muted while reset is asserted, before the registers clear.
    assign live_dph   = hreset ? 2'b00 : dph;
    assign hready_o_0 = hreset | (~pend[0] & (~dph[0] | hreadyout_i));
    assign hready_o_1 = hreset | (~pend[1] & (~dph[1] | hreadyout_i));
    assign hresp_o_0  = live_dph[0] & hresp_i;
    assign hresp_o_1  = live_dph[1] & hresp_i;
    assign hrdata_o_0 = live_dph[0] ? hrdata_i : '0;
    assign hrdata_o_1 = live_dph[1] ? hrdata_i : '0;
    assign gnt_cnt_o_0 = cnt[0];
    assign gnt_cnt_o_1 = cnt[1];

    always_ff @(posedge hclk) begin
        if (hreset) begin
            pend       <= 2'b00;
            dph        <= 2'b00;
            last_gnt   <= 1'b1;
            haddr_q    <= '0;
            hsize_q    <= 3'b000;
            hwrite_q   <= 1'b0;
            pend_write <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                pend_addr[i]  <= '0;
                pend_trans[i] <= 2'b00;
                pend_size[i]  <= 3'b000;
                cnt[i]        <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    pend[i] <= 1'b0;
                end else if (addr_ph[i] && !pend[i]) begin
                    pend[i]       <= 1'b1;
                    pend_addr[i]  <= live_addr[i];
                    pend_trans[i] <= live_trans[i];
                    pend_size[i]  <= live_size[i];
                    pend_write[i] <= live_write[i];
                end
                dph[i] <= gnt[i] | (dph[i] & ~hreadyout_i);
                if (cnt_clr_i) begin
                    cnt[i] <= '0;
                end else if (gnt[i] && !(&cnt[i])) begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
            if (grant_any) begin
                last_gnt <= sel;
                haddr_q  <= cand_addr[sel];
                hsize_q  <= cand_size[sel];
                hwrite_q <= cand_write[sel];
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_2to1_rr_arb.sv
// tb/tb_ahb_lite_2to1_rr_arb.sv - vector table, directed corner sequences and randomized model check for ahb_lite_2to1_rr_arb
module tb_ahb_lite_2to1_rr_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int CMAX = 15;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic hreset;
    logic hsel_i_0, hwrite_i_0, hready_i_0, hsel_i_1, hwrite_i_1, hready_i_1;
    logic [AW-1:0] haddr_i_0, haddr_i_1, haddr_o;
    logic [DW-1:0] hwdata_i_0, hwdata_i_1, hrdata_o_0, hrdata_o_1, hrdata_i, hwdata_o;
    logic [1:0] htrans_i_0, htrans_i_1, htrans_o;
    logic [2:0] hsize_i_0, hsize_i_1, hsize_o;
    logic hresp_o_0, hready_o_0, hresp_o_1, hready_o_1;
    logic hresp_i, hreadyout_i, hsel_o, hwrite_o, hready_o, cnt_clr_i;
    logic [CW-1:0] gnt_cnt_o_0, gnt_cnt_o_1;

    ahb_lite_2to1_rr_arb #(
        .AHB_LITE_ADDR_WIDTH(AW), .AHB_LITE_DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .hclk(hclk), .hreset(hreset),
        .hsel_i_0(hsel_i_0), .hwrite_i_0(hwrite_i_0), .hready_i_0(hready_i_0),
        .haddr_i_0(haddr_i_0), .hwdata_i_0(hwdata_i_0), .htrans_i_0(htrans_i_0), .hsize_i_0(hsize_i_0),
        .hsel_i_1(hsel_i_1), .hwrite_i_1(hwrite_i_1), .hready_i_1(hready_i_1),
        .haddr_i_1(haddr_i_1), .hwdata_i_1(hwdata_i_1), .htrans_i_1(htrans_i_1), .hsize_i_1(hsize_i_1),
        .hresp_o_0(hresp_o_0), .hready_o_0(hready_o_0), .hrdata_o_0(hrdata_o_0),
        .hresp_o_1(hresp_o_1), .hready_o_1(hready_o_1), .hrdata_o_1(hrdata_o_1),
        .hresp_i(hresp_i), .hreadyout_i(hreadyout_i), .hrdata_i(hrdata_i),
        .haddr_o(haddr_o), .hwdata_o(hwdata_o), .hsel_o(hsel_o), .hwrite_o(hwrite_o),
        .hready_o(hready_o), .htrans_o(htrans_o), .hsize_o(hsize_o),
        .gnt_cnt_o_0(gnt_cnt_o_0), .gnt_cnt_o_1(gnt_cnt_o_1), .cnt_clr_i(cnt_clr_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive(input logic s0, input logic [1:0] t0, input logic [31:0] a0,
                         input logic s1, input logic [1:0] t1, input logic [31:0] a1,
                         input logic hro, input logic resp);
        hsel_i_0 = s0; htrans_i_0 = t0; haddr_i_0 = a0; hready_i_0 = 1'b1; hwrite_i_0 = 1'b1; hsize_i_0 = 3'b010;
        hsel_i_1 = s1; htrans_i_1 = t1; haddr_i_1 = a1; hready_i_1 = 1'b1; hwrite_i_1 = 1'b0; hsize_i_1 = 3'b010;
        hwdata_i_0 = 32'hA0A0_0000; hwdata_i_1 = 32'hB1B1_0000; hrdata_i = 32'hD00D_F00D;
        hreadyout_i = hro; hresp_i = resp;
    endtask

    // Reference model: transaction-level view of who waits, who owns the data phase, grant history.
    bit            m_wait [2];
    logic [31:0]   m_waddr [2];
    logic [1:0]    m_wtrans [2];
    logic [2:0]    m_wsize [2];
    logic          m_wwrite [2];
    int            m_owner, m_last;
    int            m_cnt [2];
    logic [31:0]   m_haddr;
    logic [2:0]    m_hsize;
    logic          m_hwrite;

    task automatic model_reset();
        m_wait[0] = 0; m_wait[1] = 0;
        m_owner = -1; m_last = 1;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_haddr = '0; m_hsize = '0; m_hwrite = 1'b0;
    endtask

    task automatic reset_dut();
        hreset = 1'b1; cnt_clr_i = 1'b0;
        drive(0, 2'b00, 0, 0, 2'b00, 0, 1, 0);
        tick(); tick();
        hreset = 1'b0;
        model_reset();
    endtask

    function automatic bit live_req(input int n);
        if (n == 0) return hsel_i_0 && hready_i_0 && (htrans_i_0 == 2'b10 || htrans_i_0 == 2'b11);
        return hsel_i_1 && hready_i_1 && (htrans_i_1 == 2'b10 || htrans_i_1 == 2'b11);
    endfunction

    function automatic int m_winner();
        bit w0, w1;
        w0 = m_wait[0] || live_req(0);
        w1 = m_wait[1] || live_req(1);
        if (!hreadyout_i) return -1;
        if (w0 && w1) return 1 - m_last;
        if (w0) return 0;
        if (w1) return 1;
        return -1;
    endfunction

    task automatic rand_check(input int cyc);
        int w;
        logic [31:0] ea;
        logic [1:0]  et;
        logic [2:0]  es;
        logic        ew;
        logic [31:0] la [2];
        logic [1:0]  lt [2];
        logic [2:0]  ls [2];
        logic        lw [2];
        la[0] = haddr_i_0; la[1] = haddr_i_1; lt[0] = htrans_i_0; lt[1] = htrans_i_1;
        ls[0] = hsize_i_0; ls[1] = hsize_i_1; lw[0] = hwrite_i_0; lw[1] = hwrite_i_1;
        w = m_winner();
        if (w >= 0) begin
            ea = m_wait[w] ? m_waddr[w]  : la[w];
            et = m_wait[w] ? m_wtrans[w] : lt[w];
            es = m_wait[w] ? m_wsize[w]  : ls[w];
            ew = m_wait[w] ? m_wwrite[w] : lw[w];
        end else begin
            ea = m_haddr; et = 2'b00; es = m_hsize; ew = m_hwrite;
        end
        chk($sformatf("rnd%0d_hsel", cyc), hsel_o, w >= 0);
        chk($sformatf("rnd%0d_haddr", cyc), haddr_o, ea);
        chk($sformatf("rnd%0d_htrans", cyc), htrans_o, et);
        chk($sformatf("rnd%0d_hsize", cyc), hsize_o, es);
        chk($sformatf("rnd%0d_hwrite", cyc), hwrite_o, ew);
        chk($sformatf("rnd%0d_hready_o", cyc), hready_o, hreadyout_i);
        chk($sformatf("rnd%0d_rdy0", cyc), hready_o_0, m_wait[0] ? 1'b0 : (m_owner == 0 ? hreadyout_i : 1'b1));
        chk($sformatf("rnd%0d_rdy1", cyc), hready_o_1, m_wait[1] ? 1'b0 : (m_owner == 1 ? hreadyout_i : 1'b1));
        chk($sformatf("rnd%0d_resp0", cyc), hresp_o_0, m_owner == 0 ? hresp_i : 1'b0);
        chk($sformatf("rnd%0d_resp1", cyc), hresp_o_1, m_owner == 1 ? hresp_i : 1'b0);
        chk($sformatf("rnd%0d_rdata0", cyc), hrdata_o_0, m_owner == 0 ? hrdata_i : 32'd0);
        chk($sformatf("rnd%0d_rdata1", cyc), hrdata_o_1, m_owner == 1 ? hrdata_i : 32'd0);
        chk($sformatf("rnd%0d_wdata", cyc), hwdata_o, m_owner == 1 ? hwdata_i_1 : hwdata_i_0);
        chk($sformatf("rnd%0d_cnt0", cyc), gnt_cnt_o_0, m_cnt[0]);
        chk($sformatf("rnd%0d_cnt1", cyc), gnt_cnt_o_1, m_cnt[1]);
        for (int n = 0; n < 2; n++) begin
            if (w == n) m_wait[n] = 0;
            else if (!m_wait[n] && live_req(n)) begin
                m_wait[n] = 1; m_waddr[n] = la[n]; m_wtrans[n] = lt[n]; m_wsize[n] = ls[n]; m_wwrite[n] = lw[n];
            end
        end
        if (w >= 0) begin
            m_owner = w; m_last = w; m_haddr = ea; m_hsize = es; m_hwrite = ew;
        end else if (hreadyout_i) m_owner = -1;
        if (cnt_clr_i) begin m_cnt[0] = 0; m_cnt[1] = 0; end
        else if (w >= 0 && m_cnt[w] < CMAX) m_cnt[w] = m_cnt[w] + 1;
    endtask

    typedef struct {
        logic rst, s0; logic [1:0] t0; logic [31:0] a0;
        logic s1; logic [1:0] t1; logic [31:0] a1; logic hro, resp;
        logic e_hsel; logic [31:0] e_addr; logic [1:0] e_trans;
        logic e_r0, e_r1, e_p0, e_p1; int e_c0, e_c1;
    } vec_t;

    function automatic vec_t mkv(input logic rst, input logic s0, input logic [31:0] a0,
                                 input logic s1, input logic [31:0] a1, input logic hro, input logic resp,
                                 input logic e_hsel, input logic [31:0] e_addr, input logic [1:0] e_trans,
                                 input logic e_r0, input logic e_r1, input logic e_p0, input logic e_p1,
                                 input int e_c0, input int e_c1);
        vec_t v;
        v.rst = rst; v.s0 = s0; v.t0 = s0 ? 2'b10 : 2'b00; v.a0 = a0;
        v.s1 = s1; v.t1 = s1 ? 2'b10 : 2'b00; v.a1 = a1; v.hro = hro; v.resp = resp;
        v.e_hsel = e_hsel; v.e_addr = e_addr; v.e_trans = e_trans;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_p0 = e_p0; v.e_p1 = e_p1; v.e_c0 = e_c0; v.e_c1 = e_c1;
        return v;
    endfunction

    vec_t vt [13];

    initial begin
        int k0, k1, ng;
        vt[0]  = mkv(0, 0, 0,      0, 0,    1, 0,  0, 32'h0,    2'b00, 1, 1, 0, 0, 0, 0);
        vt[1]  = mkv(0, 1, 'h1000, 0, 0,    1, 0,  1, 32'h1000, 2'b10, 1, 1, 0, 0, 0, 0);
        vt[2]  = mkv(0, 0, 0,      0, 0,    1, 0,  0, 32'h1000, 2'b00, 1, 1, 0, 0, 1, 0);
        vt[3]  = mkv(1, 0, 0,      0, 0,    1, 0,  0, 32'h0,    2'b00, 1, 1, 0, 0, 1, 0);
        vt[4]  = mkv(0, 1, 'h10,   1, 'h20, 1, 0,  1, 32'h10,   2'b10, 1, 1, 0, 0, 0, 0);
        vt[5]  = mkv(0, 0, 0,      0, 0,    1, 0,  1, 32'h20,   2'b10, 1, 0, 0, 0, 1, 0);
        vt[6]  = mkv(0, 1, 'h30,   0, 0,    0, 0,  0, 32'h20,   2'b00, 1, 0, 0, 0, 1, 1);
        vt[7]  = mkv(0, 1, 'h30,   0, 0,    0, 0,  0, 32'h20,   2'b00, 0, 0, 0, 0, 1, 1);
        vt[8]  = mkv(0, 1, 'h30,   0, 0,    0, 0,  0, 32'h20,   2'b00, 0, 0, 0, 0, 1, 1);
        vt[9]  = mkv(0, 0, 0,      0, 0,    1, 0,  1, 32'h30,   2'b10, 0, 1, 0, 0, 1, 1);
        vt[10] = mkv(0, 0, 0,      0, 0,    0, 1,  0, 32'h30,   2'b00, 0, 1, 1, 0, 2, 1);
        vt[11] = mkv(0, 0, 0,      0, 0,    1, 1,  0, 32'h30,   2'b00, 1, 1, 1, 0, 2, 1);
        vt[12] = mkv(0, 0, 0,      0, 0,    1, 0,  0, 32'h30,   2'b00, 1, 1, 0, 0, 2, 1);

        reset_dut();
        for (int i = 0; i < 13; i++) begin
            hreset = vt[i].rst;
            drive(vt[i].s0, vt[i].t0, vt[i].a0, vt[i].s1, vt[i].t1, vt[i].a1, vt[i].hro, vt[i].resp);
            #1;
            chk($sformatf("vec%0d_hsel", i), hsel_o, vt[i].e_hsel);
            chk($sformatf("vec%0d_haddr", i), haddr_o, vt[i].e_addr);
            chk($sformatf("vec%0d_htrans", i), htrans_o, vt[i].e_trans);
            chk($sformatf("vec%0d_rdy0", i), hready_o_0, vt[i].e_r0);
            chk($sformatf("vec%0d_rdy1", i), hready_o_1, vt[i].e_r1);
            chk($sformatf("vec%0d_resp0", i), hresp_o_0, vt[i].e_p0);
            chk($sformatf("vec%0d_resp1", i), hresp_o_1, vt[i].e_p1);
            chk($sformatf("vec%0d_cnt0", i), gnt_cnt_o_0, vt[i].e_c0);
            chk($sformatf("vec%0d_cnt1", i), gnt_cnt_o_1, vt[i].e_c1);
            tick();
        end
        hreset = 1'b0;

        // Both initiators streaming eight transfers each: grants must alternate 0,1,0,1,...
        reset_dut();
        k0 = 0; k1 = 0; ng = 0;
        for (int cyc = 0; cyc < 80 && ng < 16; cyc++) begin
            drive(k0 < 8, (k0 < 8) ? 2'b10 : 2'b00, 32'h100 + k0,
                  k1 < 8, (k1 < 8) ? 2'b10 : 2'b00, 32'h200 + k1, 1, 0);
            #1;
            if (hsel_o) begin
                chk($sformatf("alt_order%0d", ng), haddr_o, (ng % 2 == 0) ? 32'h100 + ng / 2 : 32'h200 + ng / 2);
                ng++;
            end
            if (hready_o_0 && k0 < 8) k0++;
            if (hready_o_1 && k1 < 8) k1++;
            tick();
        end
        chk("alt_grants", ng, 16);
        drive(0, 2'b00, 0, 0, 2'b00, 0, 1, 0);
        #1;
        chk("alt_cnt0", gnt_cnt_o_0, 8);
        chk("alt_cnt1", gnt_cnt_o_1, 8);

        // Counter saturation and clear-beats-increment.
        reset_dut();
        for (int i = 0; i < CMAX; i++) begin
            drive(1, 2'b10, 32'h40 + i, 0, 2'b00, 0, 1, 0);
            tick();
        end
        #1;
        chk("sat_reach", gnt_cnt_o_0, CMAX);
        drive(1, 2'b11, 32'h80, 0, 2'b00, 0, 1, 0);
        #1;
        chk("sat_grant", hsel_o, 1'b1);
        tick();
        chk("sat_hold", gnt_cnt_o_0, CMAX);
        cnt_clr_i = 1'b1;
        tick();
        cnt_clr_i = 1'b0;
        chk("clr_wins", gnt_cnt_o_0, 0);
        chk("busy_no_req", 1'b0, 1'b0 | (htrans_o == 2'b01));

        // Reset asserted while initiator 1 has a pending transfer.
        reset_dut();
        drive(1, 2'b10, 32'h50, 1, 2'b10, 32'h60, 1, 0);
        #1;
        chk("rstp_first", haddr_o, 32'h50);
        tick();
        chk("rstp_pend_rdy1", hready_o_1, 1'b0);
        hreset = 1'b1;
        #1;
        chk("rstp_during_hsel", hsel_o, 1'b0);
        chk("rstp_during_haddr", haddr_o, 32'h0);
        chk("rstp_during_rdy1", hready_o_1, 1'b1);
        tick();
        hreset = 1'b0;
        drive(0, 2'b00, 0, 0, 2'b00, 0, 1, 0);
        #1;
        chk("rstp_after_hsel", hsel_o, 1'b0);
        chk("rstp_after_rdy1", hready_o_1, 1'b1);
        chk("rstp_after_cnt0", gnt_cnt_o_0, 0);
        chk("rstp_after_cnt1", gnt_cnt_o_1, 0);

        // Randomized traffic against the reference model.
        reset_dut();
        for (int cyc = 0; cyc < 400; cyc++) begin
            hsel_i_0 = ($urandom % 4) != 0; htrans_i_0 = 2'($urandom); haddr_i_0 = $urandom;
            hready_i_0 = ($urandom % 8) != 0; hwrite_i_0 = 1'($urandom); hsize_i_0 = 3'($urandom);
            hsel_i_1 = ($urandom % 4) != 0; htrans_i_1 = 2'($urandom); haddr_i_1 = $urandom;
            hready_i_1 = ($urandom % 8) != 0; hwrite_i_1 = 1'($urandom); hsize_i_1 = 3'($urandom);
            hwdata_i_0 = $urandom; hwdata_i_1 = $urandom; hrdata_i = $urandom;
            hreadyout_i = ($urandom % 4) != 0; hresp_i = ($urandom % 6) == 0;
            cnt_clr_i = ($urandom % 50) == 0;
            #1;
            rand_check(cyc);
            tick();
        end
        cnt_clr_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        hreset = 1'b1;
        cnt_clr_i = 1'b0;
        drive(0, 2'b00, 0, 0, 2'b00, 0, 1, 0);
    end
endmodule
